// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared types and helpers for the EX-stage branch resolver
package branch_resolver_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] inst_addr_t;
  typedef logic [XLEN-1:0] data_t;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } branch_op_t;

  typedef logic [1:0] bht_counter_t;

  localparam bht_counter_t BHT_WEAK_NT = 2'b01;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } resolver_state_t;

  // Saturating 2-bit counter step: toward 11 when taken, toward 00 otherwise
  function automatic bht_counter_t bht_next(input bht_counter_t cnt, input logic taken);
    bht_counter_t res;
    res = cnt;
    if (taken) begin
      if (cnt != 2'b11) res = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_resolver_bht.sv
// rtl/branch_resolver_bht.sv - 2-bit counter branch history table, async read, sync write
module branch_resolver_bht
  import branch_resolver_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               init_en,
  input  logic [IDX_W-1:0]   init_idx,
  input  logic               upd_en,
  input  logic [IDX_W-1:0]   upd_idx,
  input  logic               upd_taken,
  input  logic [IDX_W-1:0]   rd_idx,
  output bht_counter_t       rd_data
);

  bht_counter_t mem [ENTRIES];

  // IF lookup sees the stored value; a same-cycle update lands after the edge
  assign rd_data = mem[rd_idx];

  // Single write port: init sweep has priority, else read-modify-write of the counter
  always_ff @(posedge clk) begin
    if (init_en) begin
      mem[init_idx] <= BHT_WEAK_NT;
    end else if (upd_en) begin
      mem[upd_idx] <= bht_next(mem[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - EX-stage branch decision, mispredict flush/redirect and BHT owner
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int BHT_ENTRIES = 64
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_stall,
  input  logic       i_valid,
  input  logic [3:0] i_brOp,
  input  logic       i_isEqual,
  input  logic       i_isLessSigned,
  input  logic       i_isLessUnsigned,
  input  inst_addr_t i_pc,
  input  data_t      i_imm,
  input  data_t      i_dataRS1,
  input  logic       i_predTaken,
  input  inst_addr_t i_predAddr,
  input  inst_addr_t i_ifPc,
  output logic       o_ifPredTaken,
  output logic       o_ready,
  output logic       o_flush,
  output logic       o_redirect,
  output inst_addr_t o_redirectAddr,
  output logic       o_misaligned
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  resolver_state_t  state, state_next;
  logic [IDX_W-1:0] init_idx;
  logic             squash;

  branch_op_t   op;
  logic         is_cond, is_jump, taken;
  inst_addr_t   target, fallthrough, next_pc;
  logic         resolve, misalign, mispredict, bht_upd;
  bht_counter_t if_cnt;

  assign op = branch_op_t'(i_brOp);

  // Next-state: sweep the whole table once, then stay in RUN until reset
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_idx == IDX_W'(BHT_ENTRIES - 1)) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // State register and init sweep index; INIT advances regardless of stall
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) init_idx <= init_idx + 1'b1;
    end
  end

  // Branch decision from comparer flags plus target and next-PC arithmetic
  always_comb begin
    is_cond = 1'b0;
    is_jump = 1'b0;
    taken   = 1'b0;
    case (op)
      BR_BEQ:  begin is_cond = 1'b1; taken = i_isEqual;         end
      BR_BNE:  begin is_cond = 1'b1; taken = !i_isEqual;        end
      BR_BLT:  begin is_cond = 1'b1; taken = i_isLessSigned;    end
      BR_BGE:  begin is_cond = 1'b1; taken = !i_isLessSigned;   end
      BR_BLTU: begin is_cond = 1'b1; taken = i_isLessUnsigned;  end
      BR_BGEU: begin is_cond = 1'b1; taken = !i_isLessUnsigned; end
      BR_JAL:  begin is_jump = 1'b1; taken = 1'b1;              end
      BR_JALR: begin is_jump = 1'b1; taken = 1'b1;              end
      default: begin is_cond = 1'b0; taken = 1'b0;              end
    endcase
    if (op == BR_JALR) target = (i_dataRS1 + i_imm) & ~inst_addr_t'(1);
    else               target = i_pc + i_imm;
    fallthrough = i_pc + inst_addr_t'(4);
    next_pc     = taken ? target : fallthrough;
  end

  // A misaligned taken target traps instead of redirecting and leaves the BHT alone
  assign resolve    = i_valid && !i_stall && !squash && (is_cond || is_jump);
  assign misalign   = resolve && taken && (target[1:0] != 2'b00);
  assign mispredict = resolve && !misalign &&
                      ((taken != i_predTaken) || (taken && (i_predAddr != target)));
  assign bht_upd    = resolve && !misalign && is_cond && (state == ST_RUN);

  branch_resolver_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk       (i_clock),
    .init_en   (state == ST_INIT),
    .init_idx  (init_idx),
    .upd_en    (bht_upd),
    .upd_idx   (i_pc[IDX_W+1:2]),
    .upd_taken (taken),
    .rd_idx    (i_ifPc[IDX_W+1:2]),
    .rd_data   (if_cnt)
  );

  // Prediction is forced not-taken until the table has been initialised
  assign o_ifPredTaken = (state == ST_RUN) && if_cnt[1];
  assign o_ready       = (state == ST_RUN);

  // One-cycle pulses and the wrong-path squash flag, which survives stalls
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_flush        <= 1'b0;
      o_redirect     <= 1'b0;
      o_misaligned   <= 1'b0;
      o_redirectAddr <= '0;
      squash         <= 1'b0;
    end else begin
      o_flush      <= mispredict;
      o_redirect   <= mispredict;
      o_misaligned <= misalign;
      if (mispredict) o_redirectAddr <= next_pc;
      if (squash && !i_stall) squash <= 1'b0;
      else if (mispredict)    squash <= 1'b1;
    end
  end

endmodule
